// File: rtl/prio_encode_latch.sv
`default_nettype none
// ============================================================================
// Module : prio_encode_latch
// Brief  : Edge-captured 8-line priority encoder; holds one code until acked.
// Rev    : 1.0 - initial release
// ============================================================================
module prio_encode_latch (
    input  logic       clk,
    input  logic       reset,
    input  logic [7:0] req_n,
    input  logic       ei_n,
    input  logic       ack,
    output logic [2:0] code_n,
    output logic       gs_n,
    output logic       valid,
    output logic       eo_n,
    output logic [7:0] ovr
);

    localparam logic [0:0] S_IDLE    = 1'b0;
    localparam logic [0:0] S_PRESENT = 1'b1;
    localparam logic [2:0] c_NO_CODE = 3'b111;

    logic [0:0] r_state;
    logic [0:0] w_state_nxt;
    logic [7:0] r_req_prev;
    logic [7:0] r_armed;
    logic [7:0] r_pending;
    logic [7:0] r_ovr;
    logic [2:0] r_code_n;
    logic       r_gs_n;
    logic       r_valid;

    logic [7:0] w_edge;
    logic [7:0] w_set;
    logic [7:0] w_clr;
    logic [2:0] w_sel_idx;
    logic [2:0] w_code_nxt;
    logic       w_gs_nxt;
    logic       w_valid_nxt;

    // A line must be seen high after reset before its fall counts as an edge,
    // so lines held low through reset release are not captured.
    assign w_edge = r_req_prev & r_armed & ~req_n;
    assign w_set  = ei_n ? 8'h00 : w_edge;
    assign w_clr  = ((r_state == S_PRESENT) && ack) ? (8'h01 << ~r_code_n) : 8'h00;

    always_comb begin
        w_sel_idx = 3'd0;
        for (int i = 0; i < 8; i++) begin
            if (r_pending[i]) begin
                w_sel_idx = 3'(i);
            end
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        w_code_nxt  = r_code_n;
        w_gs_nxt    = r_gs_n;
        w_valid_nxt = r_valid;
        case (r_state)
            S_IDLE: begin
                if (r_pending != 8'h00) begin
                    w_state_nxt = S_PRESENT;
                    w_code_nxt  = ~w_sel_idx;
                    w_gs_nxt    = 1'b0;
                    w_valid_nxt = 1'b1;
                end else begin
                    w_code_nxt  = c_NO_CODE;
                    w_gs_nxt    = 1'b1;
                    w_valid_nxt = 1'b0;
                end
            end
            S_PRESENT: begin
                // Held until ack; newer requests never preempt.
                if (ack) begin
                    w_state_nxt = S_IDLE;
                    w_code_nxt  = c_NO_CODE;
                    w_gs_nxt    = 1'b1;
                    w_valid_nxt = 1'b0;
                end
            end
            default: begin
                w_state_nxt = S_IDLE;
                w_code_nxt  = c_NO_CODE;
                w_gs_nxt    = 1'b1;
                w_valid_nxt = 1'b0;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state    <= S_IDLE;
            r_req_prev <= 8'hFF;
            r_armed    <= req_n;
            r_pending  <= 8'h00;
            r_ovr      <= 8'h00;
            r_code_n   <= c_NO_CODE;
            r_gs_n     <= 1'b1;
            r_valid    <= 1'b0;
        end else begin
            r_state    <= w_state_nxt;
            r_req_prev <= req_n;
            r_armed    <= r_armed | req_n;
            // Set wins over a same-cycle clear.
            r_pending  <= (r_pending & ~w_clr) | w_set;
            r_ovr      <= w_set & r_pending & ~w_clr;
            r_code_n   <= w_code_nxt;
            r_gs_n     <= w_gs_nxt;
            r_valid    <= w_valid_nxt;
        end
    end

    assign code_n = r_code_n;
    assign gs_n   = r_gs_n;
    assign valid  = r_valid;
    assign ovr    = r_ovr;
    assign eo_n   = ~(~ei_n && (r_pending == 8'h00) && (r_state == S_IDLE) && (w_edge == 8'h00));

endmodule
`default_nettype wire
